ball_motion: RTL and testbench

//  Per-ball kinematics stage: owns one ball's position and signed velocity, integrates them once per frame tick,

---
 rtl/dang9_pkg.sv | 26 ++
 rtl/ball_axis_step.sv | 46 ++++
 rtl/ball_motion.sv | 167 ++++++++++++++++
 tb/tb_ball_motion.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dang9_pkg.sv
// dang9_pkg: shared widths, default table geometry, ball state encoding and the
// velocity saturation helper used by the per-ball motion stage.
package dang9_pkg;

    localparam int V_W      = 10;
    localparam int M_W      = 12;
    localparam int BALL_R   = 12;
    localparam int BALL_D   = 2 * BALL_R;
    localparam int TABLE_L  = 40;
    localparam int TABLE_R  = 600;
    localparam int TABLE_T  = 40;
    localparam int TABLE_B  = 440;
    localparam int POCKET_D = 16;

    typedef enum logic [1:0] {IDLE, MOVE, HOLD, SUNK} state_t;

    function automatic logic signed [V_W-1:0] sat(input logic signed [V_W-1:0] v,
                                                  input int lim);
        logic signed [V_W-1:0] hi;
        hi = V_W'(lim);
        if (v > hi) return hi;
        if (v < -hi) return -hi;
        return v;
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// ball_axis_step: one axis of a frame update -- integrate position, clip to the
// cushion limits (reflecting velocity), then apply the friction step toward zero.
module ball_axis_step
    import dang9_pkg::*;
(
    input  logic        [V_W-1:0] pos,
    input  logic signed [V_W-1:0] vel,
    input  logic        [V_W-1:0] lo,
    input  logic        [V_W-1:0] hi,
    input  logic                  fric_strobe,
    output logic        [V_W-1:0] next_pos,
    output logic signed [V_W-1:0] next_vel,
    output logic                  bounced
);

    logic signed [M_W-1:0] np;
    logic signed [M_W-1:0] v_ext;
    logic signed [M_W-1:0] v_b;
    logic signed [M_W-1:0] lo_s;
    logic signed [M_W-1:0] hi_s;

    // Landing exactly on a limit is a bounce, so the centre never leaves [lo, hi].
    always_comb begin
        v_ext    = M_W'(vel);
        lo_s     = signed'(M_W'(lo));
        hi_s     = signed'(M_W'(hi));
        np       = signed'(M_W'(pos)) + v_ext;
        bounced  = 1'b0;
        next_pos = np[V_W-1:0];
        v_b      = v_ext;
        if (np <= lo_s) begin
            bounced  = 1'b1;
            next_pos = lo;
            v_b      = -v_ext;
        end else if (np >= hi_s) begin
            bounced  = 1'b1;
            next_pos = hi;
            v_b      = -v_ext;
        end
        if (fric_strobe && (v_b != '0)) begin
            v_b = v_b[M_W-1] ? v_b + M_W'(1) : v_b - M_W'(1);
        end
        next_vel = v_b[V_W-1:0];
    end

endmodule

// File: rtl/ball_motion.sv
// ball_motion: one ball's position/velocity integrator with cushion bounce, friction
// and collision reload. Optional pocket detection is enabled by defining BALL_POCKET_EN.
module ball_motion
    import dang9_pkg::*;
#(
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240,
    parameter int TBL_L    = TABLE_L,
    parameter int TBL_R    = TABLE_R,
    parameter int TBL_T    = TABLE_T,
    parameter int TBL_B    = TABLE_B,
    parameter int V_MAX    = 15,
    parameter int FRIC_DIV = 8,
    parameter int COOL_FR  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  shoot_valid,
    input  logic signed [V_W-1:0] shoot_vx,
    input  logic signed [V_W-1:0] shoot_vy,
    input  logic                  coll_valid,
    input  logic signed [V_W-1:0] coll_vx,
    input  logic signed [V_W-1:0] coll_vy,
    output logic        [V_W-1:0] x,
    output logic        [V_W-1:0] y,
    output logic        [V_W-1:0] v_mag_x,
    output logic        [V_W-1:0] v_mag_y,
    output logic signed [V_W-1:0] dir_x,
    output logic signed [V_W-1:0] dir_y,
    output logic                  moving,
    output logic                  pocketed
);

    localparam int FW = (FRIC_DIV > 1) ? $clog2(FRIC_DIV) : 1;
    localparam int CW = (COOL_FR > 0) ? $clog2(COOL_FR + 1) : 1;
    localparam logic [V_W-1:0] X_LO = V_W'(TBL_L + BALL_R);
    localparam logic [V_W-1:0] X_HI = V_W'(TBL_R - BALL_R);
    localparam logic [V_W-1:0] Y_LO = V_W'(TBL_T + BALL_R);
    localparam logic [V_W-1:0] Y_HI = V_W'(TBL_B - BALL_R);

    state_t                state, state_nx;
    logic        [V_W-1:0] x_nx, y_nx;
    logic signed [V_W-1:0] vx, vy, vx_nx, vy_nx;
    logic        [FW-1:0]  fric_cnt, fric_nx;
    logic        [CW-1:0]  cool_cnt, cool_nx;
    logic        [V_W-1:0] ax_pos, ay_pos;
    logic signed [V_W-1:0] ax_vel, ay_vel;
    logic                  bx, by, unused_bounce;
    logic                  fric_wrap, stopped;
    logic                  coll_load, shoot_load, frame_upd;

    assign fric_wrap     = (fric_cnt == FW'(FRIC_DIV - 1));
    assign coll_load     = coll_valid && ((state == IDLE) || (state == MOVE));
    assign shoot_load    = shoot_valid && (state == IDLE);
    assign frame_upd     = frame_tick && ((state == MOVE) || (state == HOLD));
    assign stopped       = (ax_vel == '0) && (ay_vel == '0);
    assign unused_bounce = bx ^ by;

    ball_axis_step u_axis_x (
        .pos(x), .vel(vx), .lo(X_LO), .hi(X_HI), .fric_strobe(fric_wrap),
        .next_pos(ax_pos), .next_vel(ax_vel), .bounced(bx)
    );

    ball_axis_step u_axis_y (
        .pos(y), .vel(vy), .lo(Y_LO), .hi(Y_HI), .fric_strobe(fric_wrap),
        .next_pos(ay_pos), .next_vel(ay_vel), .bounced(by)
    );

`ifdef BALL_POCKET_EN
    logic pocketed_r, pocketed_nx, in_pocket;

    function automatic logic near(input logic [V_W-1:0] a, input int b);
        int d;
        d = int'(a) - b;
        return (d <= POCKET_D) && (d >= -POCKET_D);
    endfunction

    // Pockets sit on every (left/mid/right) x (top/bottom) y combination.
    assign in_pocket = (near(ax_pos, TBL_L) || near(ax_pos, TBL_R) ||
                        near(ax_pos, (TBL_L + TBL_R) / 2)) &&
                       (near(ay_pos, TBL_T) || near(ay_pos, TBL_B));
    assign pocketed  = pocketed_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pocketed_r <= 1'b0;
        else        pocketed_r <= pocketed_nx;
    end
`else
    assign pocketed = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x        <= V_W'(X_INIT);
            y        <= V_W'(Y_INIT);
            vx       <= '0;
            vy       <= '0;
            fric_cnt <= '0;
            cool_cnt <= '0;
        end else begin
            state    <= state_nx;
            x        <= x_nx;
            y        <= y_nx;
            vx       <= vx_nx;
            vy       <= vy_nx;
            fric_cnt <= fric_nx;
            cool_cnt <= cool_nx;
        end
    end

    // A collision load replaces the frame update of the same clk.
    always_comb begin
        state_nx = state;
        x_nx     = x;
        y_nx     = y;
        vx_nx    = vx;
        vy_nx    = vy;
        fric_nx  = fric_cnt;
        cool_nx  = cool_cnt;
`ifdef BALL_POCKET_EN
        pocketed_nx = pocketed_r;
`endif
        if (coll_load) begin
            vx_nx    = sat(coll_vx, V_MAX);
            vy_nx    = sat(coll_vy, V_MAX);
            fric_nx  = '0;
            cool_nx  = CW'(COOL_FR);
            state_nx = HOLD;
        end else if (shoot_load) begin
            vx_nx    = sat(shoot_vx, V_MAX);
            vy_nx    = sat(shoot_vy, V_MAX);
            fric_nx  = '0;
            state_nx = MOVE;
        end else if (frame_upd) begin
            x_nx    = ax_pos;
            y_nx    = ay_pos;
            vx_nx   = ax_vel;
            vy_nx   = ay_vel;
            fric_nx = fric_wrap ? '0 : fric_cnt + FW'(1);
            if (state == MOVE) begin
                if (stopped) state_nx = IDLE;
            end else begin
                cool_nx = (cool_cnt != '0) ? cool_cnt - CW'(1) : '0;
                if (cool_cnt <= CW'(1)) state_nx = stopped ? IDLE : MOVE;
            end
`ifdef BALL_POCKET_EN
            if (in_pocket) begin
                vx_nx       = '0;
                vy_nx       = '0;
                state_nx    = SUNK;
                pocketed_nx = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        v_mag_x = vx[V_W-1] ? V_W'(-vx) : V_W'(vx);
        v_mag_y = vy[V_W-1] ? V_W'(-vy) : V_W'(vy);
        dir_x   = vx[V_W-1] ? '1 : V_W'(1);
        dir_y   = vy[V_W-1] ? '1 : V_W'(1);
        moving  = (state == MOVE) || (state == HOLD);
    end

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed scenarios plus randomized traffic checked against a
// plain-arithmetic model of the ball's kinematics (default build, no pockets).
module tb_ball_motion;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_tick, shoot_valid, coll_valid;
    logic signed [9:0] shoot_vx, shoot_vy, coll_vx, coll_vy;
    logic        [9:0] x, y, v_mag_x, v_mag_y;
    logic signed [9:0] dir_x, dir_y;
    logic              moving, pocketed;

    int errors = 0;
    int checks = 0;

    localparam int XL = 52, XH = 588, YL = 52, YH = 428;
    localparam int VMAX = 15, FDIV = 8, COOL = 4;
    localparam int M_IDLE = 0, M_MOVE = 1, M_HOLD = 2;

    int m_x, m_y, m_vx, m_vy, m_ticks, m_cool, m_mode;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .shoot_valid(shoot_valid), .shoot_vx(shoot_vx), .shoot_vy(shoot_vy),
        .coll_valid(coll_valid), .coll_vx(coll_vx), .coll_vy(coll_vy),
        .x(x), .y(y), .v_mag_x(v_mag_x), .v_mag_y(v_mag_y),
        .dir_x(dir_x), .dir_y(dir_y), .moving(moving), .pocketed(pocketed)
    );

    // Reference model: ball state in plain integers, advanced by the stated rules.
    function automatic int clampv(input int v);
        return (v > VMAX) ? VMAX : ((v < -VMAX) ? -VMAX : v);
    endfunction

    function automatic int toward_zero(input int v);
        return (v > 0) ? v - 1 : ((v < 0) ? v + 1 : 0);
    endfunction

    task automatic axis_move(inout int p, inout int v, input int lo, input int hi);
        int np;
        np = p + v;
        if (np <= lo) begin p = lo; v = -v; end
        else if (np >= hi) begin p = hi; v = -v; end
        else p = np;
    endtask

    task automatic model_reset();
        m_x = 320; m_y = 240; m_vx = 0; m_vy = 0;
        m_ticks = 0; m_cool = 0; m_mode = M_IDLE;
    endtask

    task automatic model_step(input bit sv, input int sx, input int sy,
                              input bit cv, input int cx, input int cy, input bit ft);
        if (cv && m_mode != M_HOLD) begin
            m_vx = clampv(cx); m_vy = clampv(cy);
            m_ticks = 0; m_cool = COOL; m_mode = M_HOLD;
        end else if (sv && m_mode == M_IDLE) begin
            m_vx = clampv(sx); m_vy = clampv(sy);
            m_ticks = 0; m_mode = M_MOVE;
        end else if (ft && m_mode != M_IDLE) begin
            m_ticks++;
            axis_move(m_x, m_vx, XL, XH);
            axis_move(m_y, m_vy, YL, YH);
            if (m_ticks % FDIV == 0) begin
                m_vx = toward_zero(m_vx);
                m_vy = toward_zero(m_vy);
            end
            if (m_mode == M_MOVE) begin
                if (m_vx == 0 && m_vy == 0) m_mode = M_IDLE;
            end else begin
                m_cool--;
                if (m_cool == 0) m_mode = (m_vx == 0 && m_vy == 0) ? M_IDLE : M_MOVE;
            end
        end
    endtask

    // Drive one clk of inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input bit sv, input int sx, input int sy,
                        input bit cv, input int cx, input int cy, input bit ft);
        shoot_valid = sv; shoot_vx = 10'(sx); shoot_vy = 10'(sy);
        coll_valid = cv; coll_vx = 10'(cx); coll_vy = 10'(cy);
        frame_tick = ft;
        @(posedge clk); #1;
        shoot_valid = 1'b0; coll_valid = 1'b0; frame_tick = 1'b0;
        model_step(sv, sx, sy, cv, cx, cy, ft);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (x !== 10'd320) begin errors++; $display("[TB] FAIL reset_x: got %0d expected 320", x); end
        checks++; if (y !== 10'd240) begin errors++; $display("[TB] FAIL reset_y: got %0d expected 240", y); end
        checks++; if (moving !== 1'b0) begin errors++; $display("[TB] FAIL reset_moving: got %0b expected 0", moving); end
        checks++; if (dir_x !== 10'sd1) begin errors++; $display("[TB] FAIL reset_dir_x: got %0d expected 1", dir_x); end
        checks++; if (v_mag_x !== 10'd0) begin errors++; $display("[TB] FAIL reset_vmag_x: got %0d expected 0", v_mag_x); end
        checks++; if (pocketed !== 1'b0) begin errors++; $display("[TB] FAIL reset_pocketed: got %0b expected 0", pocketed); end
        ticks(3);
        checks++; if (x !== 10'd320 || moving !== 1'b0) begin errors++; $display("[TB] FAIL idle_tick: got x=%0d moving=%0b expected x=320 moving=0", x, moving); end
    endtask

    task automatic test_shoot();
        do_reset();
        step(1, 5, 0, 0, 0, 0, 0);
        checks++; if (moving !== 1'b1 || x !== 10'd320) begin errors++; $display("[TB] FAIL shoot_load: got moving=%0b x=%0d expected 1 320", moving, x); end
        ticks(3);
        checks++; if (x !== 10'd335) begin errors++; $display("[TB] FAIL shoot_x: got %0d expected 335", x); end
        checks++; if (dir_x !== 10'sd1) begin errors++; $display("[TB] FAIL shoot_dir: got %0d expected 1", dir_x); end
        checks++; if (v_mag_x !== 10'd5) begin errors++; $display("[TB] FAIL shoot_vmag: got %0d expected 5", v_mag_x); end
    endtask

    task automatic test_bounce();
        do_reset();
        step(1, 15, 0, 0, 0, 0, 0);
        ticks(17);
        checks++; if (x !== 10'd565 || v_mag_x !== 10'd13) begin errors++; $display("[TB] FAIL bounce_approach: got x=%0d v=%0d expected 565 13", x, v_mag_x); end
        step(0, 0, 0, 1, 5, 0, 0);
        ticks(4);
        checks++; if (x !== 10'd585 || v_mag_x !== 10'd5) begin errors++; $display("[TB] FAIL bounce_pre: got x=%0d v=%0d expected 585 5", x, v_mag_x); end
        ticks(1);
        checks++; if (x !== 10'd588) begin errors++; $display("[TB] FAIL bounce_x: got %0d expected 588", x); end
        checks++; if (dir_x !== -10'sd1 || v_mag_x !== 10'd5) begin errors++; $display("[TB] FAIL bounce_v: got dir=%0d mag=%0d expected -1 5", dir_x, v_mag_x); end
        ticks(1);
        checks++; if (x !== 10'd583) begin errors++; $display("[TB] FAIL bounce_after: got %0d expected 583", x); end
    endtask

    task automatic test_friction();
        int exp_mag;
        do_reset();
        step(1, 3, 0, 0, 0, 0, 0);
        for (int t = 1; t <= 24; t++) begin
            ticks(1);
            exp_mag = 3 - t / 8;
            checks++; if (v_mag_x !== 10'(exp_mag)) begin errors++; $display("[TB] FAIL fric_mag_t%0d: got %0d expected %0d", t, v_mag_x, exp_mag); end
            checks++; if (moving !== (t < 24)) begin errors++; $display("[TB] FAIL fric_moving_t%0d: got %0b expected %0b", t, moving, t < 24); end
        end
        checks++; if (x !== 10'd368) begin errors++; $display("[TB] FAIL fric_x: got %0d expected 368", x); end
    endtask

    task automatic test_collision_hold();
        do_reset();
        step(0, 0, 0, 1, -7, 20, 0);
        checks++; if (v_mag_x !== 10'd7 || dir_x !== -10'sd1) begin errors++; $display("[TB] FAIL coll_vx: got mag=%0d dir=%0d expected 7 -1", v_mag_x, dir_x); end
        checks++; if (v_mag_y !== 10'd15 || dir_y !== 10'sd1) begin errors++; $display("[TB] FAIL coll_vy_clamp: got mag=%0d dir=%0d expected 15 1", v_mag_y, dir_y); end
        checks++; if (moving !== 1'b1) begin errors++; $display("[TB] FAIL coll_moving: got %0b expected 1", moving); end
        for (int k = 1; k <= 3; k++) begin
            ticks(1);
            step(0, 0, 0, 1, 3, 3, 0);
            checks++; if (v_mag_x !== 10'd7 || dir_x !== -10'sd1) begin errors++; $display("[TB] FAIL hold_ignore_%0d: got mag=%0d dir=%0d expected 7 -1", k, v_mag_x, dir_x); end
        end
        ticks(1);
        checks++; if (x !== 10'd292 || y !== 10'd300) begin errors++; $display("[TB] FAIL hold_pos: got %0d,%0d expected 292,300", x, y); end
        step(0, 0, 0, 1, 3, 3, 0);
        checks++; if (v_mag_x !== 10'd3 || dir_x !== 10'sd1) begin errors++; $display("[TB] FAIL hold_release: got mag=%0d dir=%0d expected 3 1", v_mag_x, dir_x); end
    endtask

    task automatic test_priority_reset();
        do_reset();
        step(1, 5, 5, 1, -3, 2, 0);
        checks++; if (v_mag_x !== 10'd3 || dir_x !== -10'sd1 || v_mag_y !== 10'd2) begin errors++; $display("[TB] FAIL coll_over_shoot: got mx=%0d dx=%0d my=%0d expected 3 -1 2", v_mag_x, dir_x, v_mag_y); end
        ticks(2);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (x !== 10'd320 || y !== 10'd240) begin errors++; $display("[TB] FAIL async_rst_pos: got %0d,%0d expected 320,240", x, y); end
        checks++; if (moving !== 1'b0 || v_mag_x !== 10'd0 || dir_x !== 10'sd1) begin errors++; $display("[TB] FAIL async_rst_v: got moving=%0b mag=%0d dir=%0d expected 0 0 1", moving, v_mag_x, dir_x); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        bit sv, cv, ft;
        int sx, sy, cx, cy;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (n % 500 == 499) do_reset();
            sv = ($urandom_range(0, 7) == 0);
            cv = ($urandom_range(0, 19) == 0);
            ft = ($urandom_range(0, 2) == 0);
            sx = int'($urandom_range(0, 60)) - 30;
            sy = int'($urandom_range(0, 60)) - 30;
            cx = int'($urandom_range(0, 60)) - 30;
            cy = int'($urandom_range(0, 60)) - 30;
            step(sv, sx, sy, cv, cx, cy, ft);
            checks++; if (x !== 10'(m_x)) begin errors++; $display("[TB] FAIL rand_x@%0d: got %0d expected %0d", n, x, m_x); end
            checks++; if (y !== 10'(m_y)) begin errors++; $display("[TB] FAIL rand_y@%0d: got %0d expected %0d", n, y, m_y); end
            checks++; if (v_mag_x !== 10'((m_vx < 0) ? -m_vx : m_vx)) begin errors++; $display("[TB] FAIL rand_vmag_x@%0d: got %0d expected vx=%0d", n, v_mag_x, m_vx); end
            checks++; if (v_mag_y !== 10'((m_vy < 0) ? -m_vy : m_vy)) begin errors++; $display("[TB] FAIL rand_vmag_y@%0d: got %0d expected vy=%0d", n, v_mag_y, m_vy); end
            checks++; if (dir_x !== 10'((m_vx < 0) ? -1 : 1)) begin errors++; $display("[TB] FAIL rand_dir_x@%0d: got %0d expected vx=%0d", n, dir_x, m_vx); end
            checks++; if (dir_y !== 10'((m_vy < 0) ? -1 : 1)) begin errors++; $display("[TB] FAIL rand_dir_y@%0d: got %0d expected vy=%0d", n, dir_y, m_vy); end
            checks++; if (moving !== (m_mode != M_IDLE)) begin errors++; $display("[TB] FAIL rand_moving@%0d: got %0b expected %0b", n, moving, m_mode != M_IDLE); end
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; shoot_valid = 1'b0; coll_valid = 1'b0;
        shoot_vx = '0; shoot_vy = '0; coll_vx = '0; coll_vy = '0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_shoot();
        test_bounce();
        test_friction();
        test_collision_hold();
        test_priority_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
